// File: rtl/tlb_op_ctrl.sv
// TLB-management instruction sequencer: drives the tlb search/read/write/invalidate
// ports for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB and arbitrates search port 1.
module tlb_op_ctrl #(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_code,
  input  logic            op_cancel,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vppn,
  input  logic [18:0]     csr_vppn,
  input  logic [9:0]      csr_asid,
  input  logic [IDXW-1:0] csr_index,
  input  logic            csr_ne,
  input  logic            csr_refill,
  input  logic            mem_s1_valid,
  input  logic [18:0]     mem_s1_vppn,
  input  logic            mem_s1_va_bit12,
  input  logic [9:0]      mem_s1_asid,
  output logic            mem_s1_grant,
  output logic [18:0]     s1_vppn,
  output logic            s1_va_bit12,
  output logic [9:0]      s1_asid,
  input  logic            s1_found,
  input  logic [IDXW-1:0] s1_index,
  output logic            invtlb_valid,
  output logic [4:0]      invtlb_op,
  output logic            we,
  output logic [IDXW-1:0] w_index,
  output logic            w_e,
  output logic [IDXW-1:0] r_index,
  output logic            srch_we,
  output logic            srch_found,
  output logic [IDXW-1:0] srch_index,
  output logic            rd_we,
  output logic            done,
  output logic            op_ine
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  state_t          state, state_nxt;
  logic [2:0]      op_q;
  logic [4:0]      inv_op_q;
  logic [9:0]      inv_asid_q;
  logic [18:0]     inv_vppn_q;
  logic [IDXW-1:0] fill_ptr;
  logic            retire_q;  // op completed without cancel
  logic            ine_q;

  logic exec, live, is_srch, is_rd, is_wr, is_fill, is_inv, inv_bad, ine_cond, owns_s1;

  assign exec    = (state == S_EXEC);
  // A synchronous reset landing in EXEC must also suppress the write.
  assign live    = exec && !op_cancel && !reset;
  assign is_srch = (op_q == OP_SRCH);
  assign is_rd   = (op_q == OP_RD);
  assign is_wr   = (op_q == OP_WR);
  assign is_fill = (op_q == OP_FILL);
  assign is_inv  = (op_q == OP_INV);
  assign inv_bad = (inv_op_q > 5'd6);
  assign ine_cond = (op_q > OP_INV) || (is_inv && inv_bad);
  assign owns_s1 = exec && (is_srch || is_inv);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= '0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
      fill_ptr   <= '0;
      retire_q   <= 1'b0;
      ine_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && op_valid) begin
        op_q       <= op_code;
        inv_op_q   <= inv_op;
        inv_asid_q <= inv_asid;
        inv_vppn_q <= inv_vppn;
      end
      if (exec) begin
        retire_q <= !op_cancel;
        ine_q    <= ine_cond && !op_cancel;
      end
      if (live && is_fill)
        fill_ptr <= (fill_ptr == IDXW'(TLBNUM - 1)) ? '0 : fill_ptr + 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (op_valid) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    s1_vppn      = mem_s1_vppn;
    s1_va_bit12  = mem_s1_va_bit12;
    s1_asid      = mem_s1_asid;
    mem_s1_grant = mem_s1_valid && !owns_s1;
    if (owns_s1) begin
      s1_va_bit12 = 1'b0;
      if (is_srch) begin
        s1_vppn = csr_vppn;
        s1_asid = csr_asid;
      end else begin
        s1_vppn = inv_vppn_q;
        s1_asid = inv_asid_q;
      end
    end
  end

  always_comb begin
    w_index = '0;
    w_e     = 1'b0;
    if (exec && is_wr)   w_index = csr_index;
    if (exec && is_fill) w_index = fill_ptr;
    if (exec && (is_wr || is_fill)) w_e = csr_refill || !csr_ne;
  end

  assign op_ready     = (state == S_IDLE);
  assign we           = live && (is_wr || is_fill);
  assign r_index      = csr_index;
  assign rd_we        = live && is_rd;
  assign srch_we      = live && is_srch;
  assign srch_found   = s1_found;
  assign srch_index   = s1_index;
  assign invtlb_valid = live && is_inv && !inv_bad;
  assign invtlb_op    = inv_op_q;
  assign done         = (state == S_DONE) && retire_q;
  assign op_ine       = done && ine_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed, table-driven bench for tlb_op_ctrl: each vector is one op taken
// through accept, EXEC and DONE with hand-computed expectations.
module tb_tlb_op_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_ready, op_cancel;
  logic [2:0]  op_code;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vppn;
  logic [18:0] csr_vppn;
  logic [9:0]  csr_asid;
  logic [3:0]  csr_index;
  logic        csr_ne, csr_refill;
  logic        mem_s1_valid, mem_s1_grant, mem_s1_va_bit12;
  logic [18:0] mem_s1_vppn, s1_vppn;
  logic [9:0]  mem_s1_asid, s1_asid;
  logic        s1_va_bit12, s1_found;
  logic [3:0]  s1_index;
  logic        invtlb_valid;
  logic [4:0]  invtlb_op;
  logic        we, w_e, srch_we, srch_found, rd_we, done, op_ine;
  logic [3:0]  w_index, r_index, srch_index;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tlb_op_ctrl #(.TLBNUM(16)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_cancel(op_cancel), .inv_op(inv_op), .inv_asid(inv_asid),
    .inv_vppn(inv_vppn), .csr_vppn(csr_vppn), .csr_asid(csr_asid),
    .csr_index(csr_index), .csr_ne(csr_ne), .csr_refill(csr_refill),
    .mem_s1_valid(mem_s1_valid), .mem_s1_vppn(mem_s1_vppn),
    .mem_s1_va_bit12(mem_s1_va_bit12), .mem_s1_asid(mem_s1_asid),
    .mem_s1_grant(mem_s1_grant), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12),
    .s1_asid(s1_asid), .s1_found(s1_found), .s1_index(s1_index),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .we(we), .w_index(w_index),
    .w_e(w_e), .r_index(r_index), .srch_we(srch_we), .srch_found(srch_found),
    .srch_index(srch_index), .rd_we(rd_we), .done(done), .op_ine(op_ine)
  );

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  iop;
    logic [9:0]  iasid;
    logic [18:0] ivppn;
    logic [3:0]  cidx;
    logic        ne, refill, cancel, found;
    logic [3:0]  sidx;
    logic        e_we;
    logic [3:0]  e_widx;
    logic        e_wbit, e_inv, e_srch, e_rd, e_grant;
    logic [18:0] e_vppn;
    logic [9:0]  e_asid;
    logic        e_done, e_ine;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Applies one op from IDLE and leaves the DUT back in IDLE.
  task automatic run_op(input string tag, input vec_t v);
    op_code   = v.op;
    inv_op    = v.iop;
    inv_asid  = v.iasid;
    inv_vppn  = v.ivppn;
    csr_index = v.cidx;
    csr_ne    = v.ne;
    csr_refill = v.refill;
    s1_found  = v.found;
    s1_index  = v.sidx;
    op_valid  = 1'b1;
    #1 check({tag, " op_ready idle"}, op_ready, 1);
    tick();
    op_valid  = 1'b0;
    op_cancel = v.cancel;
    inv_op    = 5'd0;  // the op fields must have been latched at accept
    inv_asid  = 10'd0;
    inv_vppn  = 19'd0;
    #1;
    check({tag, " op_ready exec"}, op_ready, 0);
    check({tag, " we"}, we, v.e_we);
    check({tag, " w_index"}, w_index, v.e_widx);
    check({tag, " w_e"}, w_e, v.e_wbit);
    check({tag, " r_index"}, r_index, v.cidx);
    check({tag, " rd_we"}, rd_we, v.e_rd);
    check({tag, " srch_we"}, srch_we, v.e_srch);
    check({tag, " invtlb_valid"}, invtlb_valid, v.e_inv);
    check({tag, " mem_s1_grant"}, mem_s1_grant, v.e_grant);
    check({tag, " s1_vppn"}, s1_vppn, v.e_vppn);
    check({tag, " s1_asid"}, s1_asid, v.e_asid);
    check({tag, " s1_va_bit12"}, s1_va_bit12, v.e_grant ? 1 : 0);
    check({tag, " done early"}, done, 0);
    if (v.op == 3'd0) begin
      check({tag, " srch_found"}, srch_found, v.found);
      check({tag, " srch_index"}, srch_index, v.sidx);
    end
    if (v.op == 3'd4) check({tag, " invtlb_op"}, invtlb_op, v.iop);
    tick();
    op_cancel = 1'b0;
    #1;
    check({tag, " done"}, done, v.e_done);
    check({tag, " op_ine"}, op_ine, v.e_ine);
    check({tag, " op_ready done"}, op_ready, 0);
    check({tag, " we in done"}, we, 0);
    check({tag, " rd_we in done"}, rd_we, 0);
    tick();
  endtask

  vec_t tbl[10];
  vec_t f;

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    //         op  iop  iasid   ivppn     cidx ne rf cn fd sidx | we widx wb inv sr rd gr vppn       asid    dn ine
    tbl[0] = '{3'd0, 5'd0, 10'h0, 19'h0,     4'd0, 0, 0, 0, 1, 4'd7, 0, 4'd0, 0, 0, 1, 0, 0, 19'h12345, 10'h2A,  1, 0};
    tbl[1] = '{3'd2, 5'd0, 10'h0, 19'h0,     4'd5, 1, 0, 0, 0, 4'd0, 1, 4'd5, 0, 0, 0, 0, 1, 19'h7777F, 10'h155, 1, 0};
    tbl[2] = '{3'd2, 5'd0, 10'h0, 19'h0,     4'd5, 1, 1, 0, 0, 4'd0, 1, 4'd5, 1, 0, 0, 0, 1, 19'h7777F, 10'h155, 1, 0};
    tbl[3] = '{3'd4, 5'd5, 10'h3, 19'h100,   4'd0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 0, 0, 0, 19'h100,   10'h3,   1, 0};
    tbl[4] = '{3'd4, 5'd9, 10'h3, 19'h100,   4'd0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 0, 19'h100,   10'h3,   1, 1};
    tbl[5] = '{3'd3, 5'd0, 10'h0, 19'h0,     4'd0, 0, 0, 1, 0, 4'd0, 0, 4'd1, 1, 0, 0, 0, 1, 19'h7777F, 10'h155, 0, 0};
    tbl[6] = '{3'd3, 5'd0, 10'h0, 19'h0,     4'd0, 0, 0, 0, 0, 4'd0, 1, 4'd1, 1, 0, 0, 0, 1, 19'h7777F, 10'h155, 1, 0};
    tbl[7] = '{3'd1, 5'd0, 10'h0, 19'h0,     4'd3, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 1, 1, 19'h7777F, 10'h155, 1, 0};
    tbl[8] = '{3'd6, 5'd0, 10'h0, 19'h0,     4'd0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 1, 19'h7777F, 10'h155, 1, 1};
    tbl[9] = '{3'd2, 5'd0, 10'h0, 19'h0,     4'd9, 0, 0, 1, 0, 4'd0, 0, 4'd9, 1, 0, 0, 0, 1, 19'h7777F, 10'h155, 0, 0};

    reset = 1'b1; op_valid = 1'b0; op_code = '0; op_cancel = 1'b0;
    inv_op = '0; inv_asid = '0; inv_vppn = '0;
    csr_vppn = 19'h12345; csr_asid = 10'h2A; csr_index = '0; csr_ne = 1'b0; csr_refill = 1'b0;
    mem_s1_valid = 1'b1; mem_s1_vppn = 19'h7777F; mem_s1_va_bit12 = 1'b1; mem_s1_asid = 10'h155;
    s1_found = 1'b0; s1_index = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("reset op_ready", op_ready, 1);
    check("reset done", done, 0);
    check("reset we", we, 0);
    check("reset w_index", w_index, 0);
    check("reset mem_s1_grant", mem_s1_grant, 1);
    tick();

    // 17 fills walk the round-robin pointer through 0..15 and wrap to 0.
    for (int i = 0; i < 17; i++) begin
      f = '{3'd3, 5'd0, 10'h0, 19'h0, 4'd0, 0, 0, 0, 0, 4'd0, 1, 4'(i % 16), 1, 0, 0, 0, 1,
            19'h7777F, 10'h155, 1, 0};
      run_op($sformatf("fill%0d", i), f);
    end

    for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), tbl[i]);

    // op_valid held high: accepts land every third cycle.
    op_code = 3'd1; csr_index = 4'd3; op_valid = 1'b1;
    #1 check("tput ready c0", op_ready, 1);
    tick(); check("tput ready c1", op_ready, 0); check("tput rd_we c1", rd_we, 1);
    tick(); check("tput ready c2", op_ready, 0); check("tput rd_we c2", rd_we, 0);
    check("tput done c2", done, 1);
    tick(); check("tput ready c3", op_ready, 1);
    tick(); check("tput rd_we 2nd", rd_we, 1);
    op_valid = 1'b0;
    tick(); tick();

    // Synchronous reset while a write sits in EXEC.
    op_code = 3'd2; csr_index = 4'd11; op_valid = 1'b1;
    tick();
    op_valid = 1'b0; reset = 1'b1;
    #1 check("rst-exec we", we, 0);
    tick();
    reset = 1'b0;
    #1;
    check("rst-exec idle", op_ready, 1);
    check("rst-exec done", done, 0);
    f = '{3'd3, 5'd0, 10'h0, 19'h0, 4'd0, 0, 0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 0, 0, 1,
          19'h7777F, 10'h155, 1, 0};
    run_op("fill-after-reset", f);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
